// File: rtl/mem_resp_if.sv
// Bus interface between the CPU control sequencer, the mem_resp responder
// and the single-port synchronous RAM behind it.
// Optional macro: MEM_PROT_CHK_EN adds the sticky protocol error flag 'err'.
interface mem_resp_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    // Sequencer side
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          kp;
    logic          ack;
    logic [DW-1:0] rdata;

    // RAM side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

`ifdef MEM_PROT_CHK_EN
    logic          err;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output kp, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  kp, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, err
    );
`else
    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output kp, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  kp, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
`endif
endinterface

// File: rtl/mem_resp.sv
// Memory-side responder for the sequencer fetch/load bus.
// Accepts one request at a time, optionally inserts WAIT_CYC wait states,
// performs a single RAM access and returns a one-cycle ack (with read data).
// kp stays high for the whole time a request is in flight.
// Optional macro: MEM_PROT_CHK_EN adds a sticky 'err' flag raised when the
// sequencer asserts req while a request is still in flight.
module mem_resp #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int WAIT_CYC = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_resp_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACC  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Counter preload: WAIT lasts WAIT_CYC cycles, counting down to zero.
    localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    state_t        state_q,    state_d;
    logic [3:0]    cnt_q,      cnt_d;
    logic          kp_q,       kp_d;
    logic          ack_q,      ack_d;
    logic [DW-1:0] rdata_q,    rdata_d;
    logic          latWe_q,    latWe_d;
    logic [AW-1:0] latAddr_q,  latAddr_d;
    logic [DW-1:0] latWdata_q, latWdata_d;
    logic          memEn;
    logic          memWe;

    // Next-state, latch updates and the combinational RAM strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        kp_d       = kp_q;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        latWe_d    = latWe_q;
        latAddr_d  = latAddr_q;
        latWdata_d = latWdata_q;
        memEn      = 1'b0;
        memWe      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    latWe_d    = bus.we;
                    latAddr_d  = bus.addr;
                    latWdata_d = bus.wdata;
                    kp_d       = 1'b1;
                    if (WAIT_CYC == 0) begin
                        state_d = S_ACC;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACC: begin
                memEn   = 1'b1;
                memWe   = latWe_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (!latWe_q) begin
                    rdata_d = bus.mem_rdata;
                end
                ack_d   = 1'b1;
                kp_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                kp_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            kp_q       <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            latWe_q    <= 1'b0;
            latAddr_q  <= '0;
            latWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            kp_q       <= kp_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            latWe_q    <= latWe_d;
            latAddr_q  <= latAddr_d;
            latWdata_q <= latWdata_d;
        end
    end

    assign bus.kp        = kp_q;
    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = memEn;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = latAddr_q;
    assign bus.mem_wdata = latWdata_q;

`ifdef MEM_PROT_CHK_EN
    logic err_q;

    // Sticky flag: the sequencer requested while we were still busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (bus.req && kp_q) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_mem_resp.sv
// Directed testbench for mem_resp: zero-wait read, wait-state write,
// back-to-back reads, overlapping request and reset abort. Four responder
// instances with different WAIT_CYC values share clock and reset.
module tb_mem_resp;

    logic clk = 1'b0;
    logic rst_n;
    int   tests    = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_resp_if #(.AW(8), .DW(16)) b0 ();
    mem_resp_if #(.AW(8), .DW(16)) b2 ();
    mem_resp_if #(.AW(8), .DW(16)) b3 ();
    mem_resp_if #(.AW(8), .DW(16)) b4 ();

    mem_resp #(.AW(8), .DW(16), .WAIT_CYC(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    mem_resp #(.AW(8), .DW(16), .WAIT_CYC(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    mem_resp #(.AW(8), .DW(16), .WAIT_CYC(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    mem_resp #(.AW(8), .DW(16), .WAIT_CYC(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    // RAM contents: two fixed words, everything else reads back {addr, addr}.
    function automatic logic [15:0] ramRead(input logic [7:0] a);
        if (a == 8'h12) return 16'hBEEF;
        if (a == 8'h13) return 16'hC0DE;
        return {a, a};
    endfunction

    // One-cycle-latency synchronous RAM read port per instance.
    always @(posedge clk) if (b0.mem_en && !b0.mem_we) b0.mem_rdata <= ramRead(b0.mem_addr);
    always @(posedge clk) if (b2.mem_en && !b2.mem_we) b2.mem_rdata <= ramRead(b2.mem_addr);
    always @(posedge clk) if (b3.mem_en && !b3.mem_we) b3.mem_rdata <= ramRead(b3.mem_addr);
    always @(posedge clk) if (b4.mem_en && !b4.mem_we) b4.mem_rdata <= ramRead(b4.mem_addr);

    task automatic applyStimulus(input int unitId, input logic r, input logic w,
                                 input logic [7:0] a, input logic [15:0] d);
        case (unitId)
            0: begin b0.req = r; b0.we = w; b0.addr = a; b0.wdata = d; end
            2: begin b2.req = r; b2.we = w; b2.addr = a; b2.wdata = d; end
            3: begin b3.req = r; b3.we = w; b3.addr = a; b3.wdata = d; end
            default: begin b4.req = r; b4.we = w; b4.addr = a; b4.wdata = d; end
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        applyStimulus(2, 1'b0, 1'b0, 8'h00, 16'h0000);
        applyStimulus(3, 1'b0, 1'b0, 8'h00, 16'h0000);
        applyStimulus(4, 1'b0, 1'b0, 8'h00, 16'h0000);
        b0.mem_rdata = 16'h0000;
        b2.mem_rdata = 16'h0000;
        b3.mem_rdata = 16'h0000;
        b4.mem_rdata = 16'h0000;
        step();
        step();
        checkOutput("por_kp", b0.kp, 1'b0);
        checkOutput("por_rdata", b0.rdata, 16'h0000);
        rst_n = 1'b1;
        step();

        // Zero-wait read of 0x12, then back-to-back read of 0x13 in the ack cycle
        applyStimulus(0, 1'b1, 1'b0, 8'h12, 16'h0000);
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1 || c == 4) applyStimulus(0, 1'b0, 1'b0, 8'h00, 16'h0000);
            checkOutput($sformatf("zw_en_c%0d", c), b0.mem_en, (c == 1 || c == 4));
            checkOutput($sformatf("zw_we_c%0d", c), b0.mem_we, 1'b0);
            checkOutput($sformatf("zw_ack_c%0d", c), b0.ack, (c == 3 || c == 6));
            checkOutput($sformatf("zw_kp_c%0d", c), b0.kp, (c == 1 || c == 2 || c == 4 || c == 5));
            if (c == 1) checkOutput("zw_addr1", b0.mem_addr, 8'h12);
            if (c == 3) checkOutput("zw_rdata1", b0.rdata, 16'hBEEF);
            if (c == 4) checkOutput("zw_addr2", b0.mem_addr, 8'h13);
            if (c == 6) checkOutput("zw_rdata2", b0.rdata, 16'hC0DE);
            if (c == 7) checkOutput("zw_rdata_hold", b0.rdata, 16'hC0DE);
            if (c == 3) applyStimulus(0, 1'b1, 1'b0, 8'h13, 16'h0000);
        end

        // WAIT_CYC=2: read 0x40 first so rdata holds a non-zero value
        applyStimulus(2, 1'b1, 1'b0, 8'h40, 16'h0000);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) applyStimulus(2, 1'b0, 1'b0, 8'h00, 16'h0000);
            checkOutput($sformatf("w2r_ack_c%0d", c), b2.ack, (c == 5));
        end
        checkOutput("w2r_rdata", b2.rdata, 16'h4040);
        // Write 0x5A5A to 0x34, issued in the ack cycle
        applyStimulus(2, 1'b1, 1'b1, 8'h34, 16'h5A5A);
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) applyStimulus(2, 1'b0, 1'b0, 8'h00, 16'h0000);
            checkOutput($sformatf("w2w_en_c%0d", c), b2.mem_en, (c == 3));
            checkOutput($sformatf("w2w_we_c%0d", c), b2.mem_we, (c == 3));
            checkOutput($sformatf("w2w_ack_c%0d", c), b2.ack, (c == 5));
            checkOutput($sformatf("w2w_kp_c%0d", c), b2.kp, (c >= 1 && c <= 4));
            if (c <= 4) checkOutput($sformatf("w2w_addr_c%0d", c), b2.mem_addr, 8'h34);
            if (c == 3) checkOutput("w2w_wdata", b2.mem_wdata, 16'h5A5A);
            if (c >= 5) checkOutput($sformatf("w2w_rdata_c%0d", c), b2.rdata, 16'h4040);
        end

        // WAIT_CYC=3: req held for six cycles, address changed while busy
        applyStimulus(3, 1'b1, 1'b0, 8'h20, 16'h0000);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c >= 1 && c <= 5) applyStimulus(3, 1'b1, 1'b1, 8'h21, 16'hFFFF);
            if (c == 6) applyStimulus(3, 1'b0, 1'b0, 8'h00, 16'h0000);
            checkOutput($sformatf("ov_en_c%0d", c), b3.mem_en, (c == 4));
            checkOutput($sformatf("ov_we_c%0d", c), b3.mem_we, 1'b0);
            checkOutput($sformatf("ov_ack_c%0d", c), b3.ack, (c == 6));
            checkOutput($sformatf("ov_kp_c%0d", c), b3.kp, (c >= 1 && c <= 5));
            if (c == 4) checkOutput("ov_addr", b3.mem_addr, 8'h20);
            if (c == 6) checkOutput("ov_rdata", b3.rdata, 16'h2020);
`ifdef MEM_PROT_CHK_EN
            checkOutput($sformatf("ov_err_c%0d", c), b3.err, (c >= 2));
`endif
        end

        // Reset asserted mid-cycle while idle: outputs clear with no clock edge
        #4;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_kp", b0.kp, 1'b0);
        checkOutput("rst_ack", b0.ack, 1'b0);
        checkOutput("rst_rdata", b0.rdata, 16'h0000);
        checkOutput("rst_en", b0.mem_en, 1'b0);
        checkOutput("rst_we", b0.mem_we, 1'b0);
        checkOutput("rst_rdata3", b3.rdata, 16'h0000);
`ifdef MEM_PROT_CHK_EN
        checkOutput("rst_err", b3.err, 1'b0);
`endif
        #1;
        rst_n = 1'b1;
        step();

        // WAIT_CYC=4: abort with reset during WAIT
        applyStimulus(4, 1'b1, 1'b0, 8'h50, 16'h0000);
        step();
        applyStimulus(4, 1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("ab_kp_c1", b4.kp, 1'b1);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("ab_kp_rst", b4.kp, 1'b0);
        #1;
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            checkOutput($sformatf("ab_en_c%0d", c), b4.mem_en, 1'b0);
            checkOutput($sformatf("ab_ack_c%0d", c), b4.ack, 1'b0);
            checkOutput($sformatf("ab_kp_c%0d", c), b4.kp, 1'b0);
        end
        // A fresh request afterwards completes with latency 7
        applyStimulus(4, 1'b1, 1'b0, 8'h51, 16'h0000);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) applyStimulus(4, 1'b0, 1'b0, 8'h00, 16'h0000);
            checkOutput($sformatf("ab2_en_c%0d", c), b4.mem_en, (c == 5));
            checkOutput($sformatf("ab2_ack_c%0d", c), b4.ack, (c == 7));
            checkOutput($sformatf("ab2_kp_c%0d", c), b4.kp, (c >= 1 && c <= 6));
            if (c == 5) checkOutput("ab2_addr", b4.mem_addr, 8'h51);
            if (c == 7) checkOutput("ab2_rdata", b4.rdata, 16'h5151);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Memory-side responder for the CPU control sequencer's fetch/load bus; services opcode fetch, operand fetch and data load/store requests.
- Drives a single-port synchronous RAM (1-cycle read latency) and inserts a programmable number of wait states.
- Produces the `kp` (keep/wait) signal the sequencer samples in EXE/LOAD, and returns read data with a one-cycle `ack`.

Parameters:
- AW, 8, address width.
- DW, 16, data width.
- WAIT_CYC, 0, wait states inserted before the RAM access; legal range 0..15 (4-bit counter).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  1  access request from the sequencer; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  AW  request address; qualified by req.
- wdata  in  DW  write data; qualified by req.
- kp  out  1  busy/keep, registered; high while a request is in flight.
- ack  out  1  registered one-cycle completion pulse.
- rdata  out  DW  registered read data; valid while ack=1, holds otherwise.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address (latched request address).
- mem_wdata  out  DW  RAM write data (latched request data).
- mem_rdata  in  DW  RAM read data; valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (async, any state): state=IDLE, kp=0, ack=0, rdata=0, latched addr/wdata/we=0, counter=0. mem_en=0 and mem_we=0 immediately.
- States: IDLE, WAIT, ACC, RESP. Use a 2-bit encoding; unreachable codes return to IDLE.
- IDLE:
  - If req=1, latch we/addr/wdata and set kp<=1.
  - If WAIT_CYC=0, go to ACC. Otherwise go to WAIT with cnt<=WAIT_CYC-1.
  - If req=0, remain in IDLE.
- WAIT: if cnt==0 go to ACC, else cnt<=cnt-1. WAIT lasts exactly WAIT_CYC cycles.
- ACC: mem_en=1 and mem_we=latched we, both combinational, for exactly one cycle. Go to RESP.
- RESP (exit edge):
  - Read: rdata<=mem_rdata. Write: rdata holds.
  - ack<=1, kp<=0, go to IDLE.
- ack is forced to 0 on every edge except the RESP exit.
- Timing for a req accepted in cycle t:
  - WAIT occupies t+1..t+WAIT_CYC.
  - ACC is t+WAIT_CYC+1.
  - RESP is t+WAIT_CYC+2.
  - ack=1, kp=0 and rdata valid at t+WAIT_CYC+3.
  - kp is high for WAIT_CYC+2 cycles.
- Back-to-back: the ack cycle is IDLE, so a req in that cycle is accepted. kp re-rises the following cycle, and ack is not high simultaneously with kp.
- req while kp=1 is ignored: no latch update, no extra RAM access. The sequencer must not rely on queuing.
- mem_addr and mem_wdata are driven continuously from the latches; they are stable through WAIT/ACC/RESP.
- Reset mid-operation aborts the access with no ack. If reset hits in ACC, the RAM write may or may not have occurred; this is unspecified and not checked.

Optional Feature:
- MEM_PROT_CHK_EN defined:
  - Adds output port `err` (1 bit, registered).
  - err<=1 on any edge where req=1 and kp=1.
  - err is sticky until rst_n=0; reset value 0.
  - Functional behaviour is otherwise identical.
- MEM_PROT_CHK_EN undefined: no `err` port and no checking logic.

Test Plan:
- Reset values: assert rst_n=0 mid-idle -> kp=0, ack=0, rdata=0x0000, mem_en=0, mem_we=0 immediately, with no clock edge needed.
- Zero-wait read:
  - Stimulus: WAIT_CYC=0; req=1, we=0, addr=0x12 in cycle 0; RAM returns 0xBEEF.
  - Response: mem_en=1, mem_addr=0x12 in cycle 1; kp=1 in cycles 1-2; ack=1, rdata=0xBEEF in cycle 3 only.
- Wait-state write:
  - Stimulus: WAIT_CYC=2; req=1, we=1, addr=0x34, wdata=0x5A5A in cycle 0.
  - Response: mem_en=mem_we=1 in cycle 3 only, with mem_wdata=0x5A5A; ack=1 in cycle 5; kp=1 in cycles 1-4; rdata keeps its prior value.
- Back-to-back reads:
  - Stimulus: WAIT_CYC=0; second req (addr=0x13) asserted in the first ack cycle 3.
  - Response: accepted; mem_en in cycle 4 with addr 0x13; second ack in cycle 6; exactly two mem_en pulses.
- Overlap:
  - Stimulus: WAIT_CYC=3; req held high for 6 cycles from cycle 0.
  - Response: exactly one mem_en pulse (cycle 4) and one ack (cycle 6).
  - With MEM_PROT_CHK_EN: err=1 from cycle 2 onward and stays 1 after the access ends.
- Abort:
  - Stimulus: WAIT_CYC=4; rst_n=0 asserted in cycle 2 (WAIT).
  - Response: kp=0 immediately; no mem_en and no ack through cycle 10 after rst_n release.
  - A new req then completes normally with latency WAIT_CYC+3.
